zap_tag_ram_assoc: RTL and testbench

Parametrised N-way set-associative tag store with per-way valid bits, single-cycle global flush, single-set invalidate, registered tag compare and per-set round-robin victim selection. Used by the cache and TLB front ends, which need multi-way lookup, hit detection and replacement in place of a direct-mapped tag RAM with whole-array clear only. One instance per cache/TLB; sits between the lookup pipeline stage and the refill controller.

---
 rtl/zap_tag_pkg.sv | 35 +++
 rtl/zap_ram_simple.sv | 36 +++
 rtl/zap_tag_ram_assoc.sv | 212 +++++++++++++++++++++
 tb/tb_zap_tag_ram_assoc.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/zap_tag_pkg.sv
// Shared definitions for the associative tag store: index-width helper and
// priority-encode / one-hot helpers used for victim and hit-way selection.
package zap_tag_pkg;

  // Widest associativity the helpers below are sized for.
  localparam int MAX_WAYS = 32;

  // Index width for n entries, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic int lowest_set_idx(input logic [MAX_WAYS-1:0] v);
    int idx;
    idx = 0;
    for (int i = MAX_WAYS - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = i;
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // One-hot of the lowest set bit; all zeros when no bit is set.
  function automatic logic [MAX_WAYS-1:0] lowest_one_hot(input logic [MAX_WAYS-1:0] v);
    logic [MAX_WAYS-1:0] r;
    r = '0;
    r[lowest_set_idx(v)] = |v;
    return r;
  endfunction

endpackage

// File: rtl/zap_ram_simple.sv
// Single-port-per-direction payload RAM for one way: synchronous write,
// registered read that updates only when a lookup is issued (read-before-write
// on address collision).
module zap_ram_simple #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 20
) (
  input  logic                     i_clk,
  input  logic                     i_wen,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_ren,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Array write on refill.
  always_ff @(posedge i_clk) begin
    if (i_wen) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  // Read register captures the addressed word only on a lookup, else holds.
  always_ff @(posedge i_clk) begin
    if (i_ren) begin
      rdata_q <= mem_q[i_raddr];
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/zap_tag_ram_assoc.sv
// N-way set-associative tag store: per-way valid bits, global flush, set
// invalidate, registered lookup with tag compare and per-set round-robin
// victim selection. Optional macro ZAP_TAG_RAM_BYPASS_EN forwards a
// same-cycle same-set refill (and set invalidate) into the lookup result.
module zap_tag_ram_assoc
  import zap_tag_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int DEPTH = 32,
  parameter int WIDTH = 20
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_inv,
  input  logic                     i_inv_set_en,
  input  logic [$clog2(DEPTH)-1:0] i_inv_set,
  input  logic                     i_ren,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  input  logic [WIDTH-1:0]         i_rtag,
  input  logic                     i_wen,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WAYS*WIDTH-1:0]    o_rdata,
  output logic [WAYS-1:0]          o_rdav,
  output logic                     o_hit,
  output logic [WAYS-1:0]          o_hit_way,
  output logic [WAYS-1:0]          o_wway
);

  localparam int WW = idx_width(WAYS);

  // Architectural state.
  logic [WAYS-1:0]       dav_q [DEPTH];
  logic [WAYS-1:0]       dav_d [DEPTH];
  logic [WW-1:0]         rr_q  [DEPTH];
  logic [WW-1:0]         rr_d  [DEPTH];
  logic [WAYS-1:0]       rdav_q, rdav_d;
  logic [WIDTH-1:0]      tag_q, tag_d;
  logic [WAYS-1:0]       wway_q, wway_d;

  // Combinational helpers.
  logic [WAYS-1:0]       set_dav_s;
  logic                  set_full_s;
  logic [WW-1:0]         victim_idx_s;
  logic [WAYS-1:0]       victim_oh_s;
  logic                  same_set_inv_s;
  logic [WAYS-1:0]       look_dav_s;
  logic [WAYS*WIDTH-1:0] ram_rdata_s;
  logic [WAYS*WIDTH-1:0] rdata_s;
  logic [WAYS-1:0]       match_s;
  logic [WAYS-1:0]       hit_way_s;

  // One payload RAM per way; every way sees the refill address, only the victim writes.
  for (genvar k = 0; k < WAYS; k++) begin : g_way
    zap_ram_simple #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
    ) u_ram (
      .i_clk   (i_clk),
      .i_wen   (i_wen & victim_oh_s[k]),
      .i_waddr (i_waddr),
      .i_wdata (i_wdata),
      .i_ren   (i_ren),
      .i_raddr (i_raddr),
      .o_rdata (ram_rdata_s[k*WIDTH +: WIDTH])
    );
  end

  // Victim: lowest invalid way of the refill set, else its round-robin way.
  always_comb begin
    set_dav_s  = dav_q[i_waddr];
    set_full_s = &set_dav_s;
    if (set_full_s) begin
      victim_idx_s = rr_q[i_waddr];
    end else begin
      victim_idx_s = WW'(lowest_set_idx(MAX_WAYS'(~set_dav_s)));
    end
    victim_oh_s    = WAYS'(1'b1) << victim_idx_s;
    same_set_inv_s = i_inv_set_en && (i_inv_set == i_waddr);
  end

  // Valid / round-robin next state: flush beats set invalidate beats refill.
  always_comb begin
    dav_d = dav_q;
    rr_d  = rr_q;
    if (i_inv) begin
      for (int s = 0; s < DEPTH; s++) begin
        dav_d[s] = '0;
      end
    end else begin
      if (i_wen) begin
        dav_d[i_waddr] = dav_q[i_waddr] | victim_oh_s;
        if (set_full_s && !same_set_inv_s) begin
          rr_d[i_waddr] = rr_q[i_waddr] + WW'(1'b1);
        end else begin
          rr_d[i_waddr] = rr_q[i_waddr];
        end
      end else begin
        dav_d[i_waddr] = dav_q[i_waddr];
      end
      if (i_inv_set_en) begin
        dav_d[i_inv_set] = '0;
      end else begin
        dav_d[i_inv_set] = dav_d[i_inv_set];
      end
    end
  end

  // Lookup valid capture (with optional forwarding), tag capture and written-way report.
  always_comb begin
    look_dav_s = dav_q[i_raddr];
`ifdef ZAP_TAG_RAM_BYPASS_EN
    if (i_wen && (i_waddr == i_raddr)) begin
      look_dav_s = look_dav_s | victim_oh_s;
    end else begin
      look_dav_s = look_dav_s;
    end
    if (i_inv_set_en && (i_inv_set == i_raddr)) begin
      look_dav_s = '0;
    end else begin
      look_dav_s = look_dav_s;
    end
`endif
    if (i_inv) begin
      rdav_d = '0;
    end else if (i_ren) begin
      rdav_d = look_dav_s;
    end else begin
      rdav_d = rdav_q;
    end
    if (i_ren) begin
      tag_d = i_rtag;
    end else begin
      tag_d = tag_q;
    end
    if (i_wen && !i_inv) begin
      wway_d = victim_oh_s;
    end else begin
      wway_d = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int s = 0; s < DEPTH; s++) begin
        dav_q[s] <= '0;
        rr_q[s]  <= '0;
      end
      rdav_q <= '0;
      tag_q  <= '0;
      wway_q <= '0;
    end else begin
      dav_q  <= dav_d;
      rr_q   <= rr_d;
      rdav_q <= rdav_d;
      tag_q  <= tag_d;
      wway_q <= wway_d;
    end
  end

`ifdef ZAP_TAG_RAM_BYPASS_EN
  logic [WAYS-1:0]  fwd_lane_q;
  logic [WIDTH-1:0] fwd_data_q;

  // Remember which lane (if any) the lookup must take from the refill data.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fwd_lane_q <= '0;
      fwd_data_q <= '0;
    end else if (i_ren) begin
      fwd_lane_q <= (i_wen && (i_waddr == i_raddr)) ? victim_oh_s : '0;
      fwd_data_q <= i_wdata;
    end else begin
      fwd_lane_q <= fwd_lane_q;
      fwd_data_q <= fwd_data_q;
    end
  end

  // Per-lane select between RAM read data and forwarded refill data.
  always_comb begin
    rdata_s = ram_rdata_s;
    for (int k = 0; k < WAYS; k++) begin
      if (fwd_lane_q[k]) begin
        rdata_s[k*WIDTH +: WIDTH] = fwd_data_q;
      end else begin
        rdata_s[k*WIDTH +: WIDTH] = ram_rdata_s[k*WIDTH +: WIDTH];
      end
    end
  end
`else
  // Lookup data comes straight from the per-way read registers.
  always_comb begin
    rdata_s = ram_rdata_s;
  end
`endif

  // Tag compare on the captured lookup; lowest matching valid way wins.
  always_comb begin
    for (int k = 0; k < WAYS; k++) begin
      match_s[k] = rdav_q[k] && (rdata_s[k*WIDTH +: WIDTH] == tag_q);
    end
    hit_way_s = WAYS'(lowest_one_hot(MAX_WAYS'(match_s)));
  end

  assign o_rdata   = rdata_s;
  assign o_rdav    = rdav_q;
  assign o_hit     = |hit_way_s;
  assign o_hit_way = hit_way_s;
  assign o_wway    = wway_q;

endmodule

// File: tb/tb_zap_tag_ram_assoc.sv
// Self-checking bench for zap_tag_ram_assoc: directed scenarios with literal
// expectations, then randomized traffic against a behavioural set/way model.
module tb_zap_tag_ram_assoc;

  localparam int WAYS  = 2;
  localparam int DEPTH = 32;
  localparam int WIDTH = 20;
  localparam int AW    = $clog2(DEPTH);

  logic                  clk;
  logic                  rst;
  logic                  inv;
  logic                  ise;
  logic [AW-1:0]         iset;
  logic                  ren;
  logic [AW-1:0]         raddr;
  logic [WIDTH-1:0]      rtag;
  logic                  wen;
  logic [AW-1:0]         waddr;
  logic [WIDTH-1:0]      wdata;
  logic [WAYS*WIDTH-1:0] o_rdata;
  logic [WAYS-1:0]       o_rdav;
  logic                  o_hit;
  logic [WAYS-1:0]       o_hit_way;
  logic [WAYS-1:0]       o_wway;

  zap_tag_ram_assoc #(.WAYS(WAYS), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_inv        (inv),
    .i_inv_set_en (ise),
    .i_inv_set    (iset),
    .i_ren        (ren),
    .i_raddr      (raddr),
    .i_rtag       (rtag),
    .i_wen        (wen),
    .i_waddr      (waddr),
    .i_wdata      (wdata),
    .o_rdata      (o_rdata),
    .o_rdav       (o_rdav),
    .o_hit        (o_hit),
    .o_hit_way    (o_hit_way),
    .o_wway       (o_wway)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: contents, valid bits and replacement pointer per set.
  logic [WIDTH-1:0] m_mem [WAYS][DEPTH];
  bit               m_val [WAYS][DEPTH];
  int               m_rr  [DEPTH];
  logic [WIDTH-1:0] e_rd  [WAYS];
  logic [WAYS-1:0]  e_rv;
  logic [WIDTH-1:0] e_tag;
  logic [WAYS-1:0]  e_wway;

  int n_chk;
  int n_pass;
  bit cmp_en;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one clock of the input rules to the model, using pre-edge state.
  task automatic model_step();
    bit full;
    int vic;
    full = 1'b1;
    for (int k = 0; k < WAYS; k++) if (!m_val[k][waddr]) full = 1'b0;
    if (full) begin
      vic = m_rr[waddr];
    end else begin
      vic = -1;
      for (int k = 0; k < WAYS; k++) if (!m_val[k][waddr] && vic < 0) vic = k;
    end
    if (rst) begin
      if (wen) m_mem[vic][waddr] = wdata;
      for (int s = 0; s < DEPTH; s++) begin
        m_rr[s] = 0;
        for (int k = 0; k < WAYS; k++) m_val[k][s] = 1'b0;
      end
      e_rv   = '0;
      e_wway = '0;
      return;
    end
    if (ren) begin
      for (int k = 0; k < WAYS; k++) begin
        e_rd[k] = m_mem[k][raddr];
        e_rv[k] = m_val[k][raddr];
      end
      e_tag = rtag;
`ifdef ZAP_TAG_RAM_BYPASS_EN
      if (wen && waddr == raddr) begin
        e_rd[vic] = wdata;
        e_rv[vic] = 1'b1;
      end
      if (ise && iset == raddr) e_rv = '0;
`endif
    end
    if (inv) e_rv = '0;
    e_wway = '0;
    if (wen) begin
      m_mem[vic][waddr] = wdata;
      if (!inv) begin
        e_wway = WAYS'(1) << vic;
        m_val[vic][waddr] = 1'b1;
        if (full && !(ise && iset == waddr)) m_rr[waddr] = (m_rr[waddr] + 1) % WAYS;
      end
    end
    if (inv) begin
      for (int s = 0; s < DEPTH; s++)
        for (int k = 0; k < WAYS; k++) m_val[k][s] = 1'b0;
    end else if (ise) begin
      for (int k = 0; k < WAYS; k++) m_val[k][iset] = 1'b0;
    end
  endtask

  // Every-cycle comparison of DUT outputs with the model.
  initial begin
    logic [WAYS-1:0] exp_hw;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        exp_hw = '0;
        for (int k = 0; k < WAYS; k++)
          if (e_rv[k] && e_rd[k] == e_tag && exp_hw == '0) exp_hw = WAYS'(1) << k;
        chk("rdav", 64'(o_rdav), 64'(e_rv));
        chk("wway", 64'(o_wway), 64'(e_wway));
        chk("hit_way", 64'(o_hit_way), 64'(exp_hw));
        chk("hit", 64'(o_hit), 64'(exp_hw != '0));
        for (int k = 0; k < WAYS; k++)
          if (e_rv[k]) chk("rdata", 64'(o_rdata[k*WIDTH +: WIDTH]), 64'(e_rd[k]));
      end
    end
  end

  task automatic idle();
    rst = 1'b0; inv = 1'b0; ise = 1'b0; iset = '0;
    ren = 1'b0; raddr = '0; rtag = '0;
    wen = 1'b0; waddr = '0; wdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic wr(input int s, input logic [WIDTH-1:0] d);
    idle(); wen = 1'b1; waddr = AW'(s); wdata = d; step();
  endtask

  task automatic rd(input int s, input logic [WIDTH-1:0] t);
    idle(); ren = 1'b1; raddr = AW'(s); rtag = t; step();
  endtask

  logic [WIDTH-1:0] pool [8];

  initial begin
    n_chk = 0; n_pass = 0; cmp_en = 1'b0;
    idle();
    rst = 1'b1;
    step();
    cmp_en = 1'b1;
    rst = 1'b1;
    step();

    // Reset state then lookup of an empty set.
    rd(3, 20'h00000);
    chk("reset_rdav", 64'(o_rdav), 64'h0);
    chk("reset_hit", 64'(o_hit), 64'h0);
    chk("reset_hitway", 64'(o_hit_way), 64'h0);

    // Fill set 5 and look up the second tag.
    wr(5, 20'hABCDE);
    chk("fill_wway0", 64'(o_wway), 64'h1);
    wr(5, 20'h12345);
    chk("fill_wway1", 64'(o_wway), 64'h2);
    rd(5, 20'h12345);
    chk("look_rdav", 64'(o_rdav), 64'h3);
    chk("look_hit", 64'(o_hit), 64'h1);
    chk("look_hitway", 64'(o_hit_way), 64'h2);
    chk("look_lane0", 64'(o_rdata[0 +: WIDTH]), 64'hABCDE);
    chk("look_lane1", 64'(o_rdata[WIDTH +: WIDTH]), 64'h12345);
    chk("look_wway_idle", 64'(o_wway), 64'h0);

    // Round-robin replacement on the full set.
    wr(5, 20'h11111);
    chk("rr_third", 64'(o_wway), 64'h1);
    wr(5, 20'h22222);
    chk("rr_fourth", 64'(o_wway), 64'h2);
    wr(5, 20'h33333);
    chk("rr_fifth", 64'(o_wway), 64'h1);
    wr(6, 20'h66666);
    chk("set6_wway", 64'(o_wway), 64'h1);

    // Set invalidate colliding with a refill of the same set.
    idle(); ise = 1'b1; iset = AW'(5); wen = 1'b1; waddr = AW'(5); wdata = 20'h44444; step();
    chk("inv_set_wway", 64'(o_wway), 64'h2);
    rd(5, 20'h44444);
    chk("inv_set_rdav", 64'(o_rdav), 64'h0);
    rd(6, 20'h66666);
    chk("set6_rdav", 64'(o_rdav), 64'h1);
    chk("set6_hitway", 64'(o_hit_way), 64'h1);
    idle(); step();
    chk("hold_rdav", 64'(o_rdav), 64'h1);

    // Flush during a refill.
    idle(); inv = 1'b1; wen = 1'b1; waddr = AW'(2); wdata = 20'h2A2A2; step();
    chk("flush_wway", 64'(o_wway), 64'h0);
    chk("flush_rdav_now", 64'(o_rdav), 64'h0);
    rd(2, 20'h2A2A2);
    chk("flush_rdav", 64'(o_rdav), 64'h0);

    // Same-cycle read and write of an empty set.
    idle(); ren = 1'b1; raddr = AW'(7); rtag = 20'h77777;
    wen = 1'b1; waddr = AW'(7); wdata = 20'h77777; step();
`ifdef ZAP_TAG_RAM_BYPASS_EN
    chk("rw_same_rdav", 64'(o_rdav), 64'h1);
    chk("rw_same_hit", 64'(o_hit), 64'h1);
`else
    chk("rw_same_rdav", 64'(o_rdav), 64'h0);
    chk("rw_same_hit", 64'(o_hit), 64'h0);
`endif
    rd(7, 20'h77777);
    chk("rw_after_hit", 64'(o_hit), 64'h1);
    chk("rw_after_lane0", 64'(o_rdata[0 +: WIDTH]), 64'h77777);

    // Randomized traffic on a few sets with a small tag pool.
    for (int i = 0; i < 8; i++) pool[i] = WIDTH'($urandom);
    for (int c = 0; c < 4000; c++) begin
      idle();
      rst   = ($urandom_range(0, 299) == 0);
      inv   = ($urandom_range(0, 79) == 0);
      ise   = ($urandom_range(0, 9) == 0);
      iset  = AW'($urandom_range(0, 3));
      ren   = ($urandom_range(0, 1) == 1);
      raddr = AW'($urandom_range(0, 3));
      rtag  = pool[$urandom_range(0, 7)];
      wen   = ($urandom_range(0, 2) != 0);
      waddr = AW'($urandom_range(0, 3));
      wdata = pool[$urandom_range(0, 7)];
      step();
    end

    cmp_en = 1'b0;
    idle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
